rr_grant_ctrl: RTL and testbench

Round-robin grant controller for the request arbiter; the stage directly downstream of the thermometer priority mask logic. Keeps the last-granted index and derives a registered thermometer mask from it. Picks one requester with masked-then-unmasked find-first priority and holds a registered one-hot grant until release or a hold-limit timeout.

---
 rtl/rr_arb_pkg.sv | 37 +++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_grant_ctrl.sv | 126 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant controller.
//
// Contents:
//   state_t    - controller FSM state (IDLE: no grant, BUSY: one grant out)
//   find_first - index of the lowest set bit of a vector (0 when empty)
//   onehot     - index to one-hot vector
//   thermo     - thermometer mask with bit k set iff k > idx
//
// Vectors are carried as 32 bits, which is the largest supported
// requester count; callers size-cast to their own width.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int find_first(input logic [31:0] v);
        find_first = 0;
        // Walk downwards so the last hit is the lowest set bit.
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) find_first = i;
        end
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        onehot = 32'd1 << idx;
    endfunction

    function automatic logic [31:0] thermo(input int idx);
        thermo = '0;
        for (int i = 0; i < 32; i++) begin
            thermo[i] = (i > idx);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester above the last grant
// (req & mask), falling back to the lowest requester overall.
//
// Ports:
//   req    [N-1:0]     level requests
//   mask   [N-1:0]     thermometer mask, bit k set iff k > last grant
//   winner [ID_W-1:0]  selected requester index (valid when any=1)
//   any                at least one request is present
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int request_lines = 4,
    parameter int ID_W          = $clog2(request_lines)
) (
    input  logic [request_lines-1:0] req,
    input  logic [request_lines-1:0] mask,
    output logic [ID_W-1:0]          winner,
    output logic                     any
);

    logic [request_lines-1:0] masked;

    always_comb begin
        masked = req & mask;
        any    = |req;
        if (|masked) begin
            winner = ID_W'(find_first(32'(masked)));
        end else begin
            winner = ID_W'(find_first(32'(req)));
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller. Picks one requester, holds a registered
// one-hot grant until the owner releases it, withdraws its request, or the
// hold limit expires, then rotates priority past the released index.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        [N-1:0] level requests, held until granted
//   done       owner releases its grant (only meaningful while gnt_valid=1)
//   gnt        [N-1:0] registered one-hot grant
//   gnt_valid  registered, OR of gnt
//   gnt_id     registered index of the current or last grant
//   mask       registered thermometer mask, bit k set iff k > last grant
//   timeout    one-cycle pulse when the hold limit revokes a grant
//   fsm_state  current FSM state, for observation
//
// Handshake: a grant is offered by gnt/gnt_valid; the owner ends it with a
// single-cycle done while gnt_valid=1, or by dropping its req bit. done is
// ignored while no grant is outstanding. Consecutive grants are always
// separated by at least one cycle with gnt=0.
module rr_grant_ctrl
    import rr_arb_pkg::*;
#(
    parameter int request_lines = 4,
    parameter int max_hold      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [request_lines-1:0]         req,
    input  logic                             done,
    output logic [request_lines-1:0]         gnt,
    output logic                             gnt_valid,
    output logic [$clog2(request_lines)-1:0] gnt_id,
    output logic [request_lines-1:0]         mask,
    output logic                             timeout,
    output state_t                           fsm_state
);

    localparam int N      = request_lines;
    localparam int ID_W   = $clog2(request_lines);
    localparam int HOLD_W = $clog2(max_hold);

    // The last granted index is kept only in its thermometer form: mask
    // is rewritten from gnt_id at every release, and reset to all zeros
    // (equivalent to last index N-1, giving index 0 priority).
    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [N-1:0]      gnt_n, mask_n;
    logic              gnt_valid_n, timeout_n;
    logic [ID_W-1:0]   gnt_id_n;

    logic [ID_W-1:0]   winner;
    logic              any;
    logic              rel_done, rel_withdraw, rel_limit;

    rr_pick #(
        .request_lines(N),
        .ID_W         (ID_W)
    ) u_pick (
        .req   (req),
        .mask  (mask),
        .winner(winner),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            mask      <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            gnt_id    <= gnt_id_n;
            mask      <= mask_n;
            timeout   <= timeout_n;
        end
    end

    always_comb begin
        state_n      = state;
        hold_n       = hold_cnt;
        gnt_n        = gnt;
        gnt_valid_n  = gnt_valid;
        gnt_id_n     = gnt_id;
        mask_n       = mask;
        timeout_n    = 1'b0;
        rel_done     = done;
        rel_withdraw = !req[gnt_id];
        rel_limit    = (hold_cnt == HOLD_W'(max_hold - 1));

        case (state)
            IDLE: begin
                if (any) begin
                    gnt_n       = N'(onehot(int'(winner)));
                    gnt_id_n    = winner;
                    gnt_valid_n = 1'b1;
                    hold_n      = '0;
                    state_n     = BUSY;
                end
            end
            BUSY: begin
                if (rel_done || rel_withdraw || rel_limit) begin
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    mask_n      = N'(thermo(int'(gnt_id)));
                    state_n     = IDLE;
                    // Only a pure hold-limit release counts as a revocation.
                    timeout_n   = rel_limit && !rel_done && !rel_withdraw;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;
  import rr_arb_pkg::*;

  localparam int N = 4;
  localparam int MH = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic [N-1:0] mask;
  logic         timeout;
  state_t       fsm_state;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.request_lines(N), .max_hold(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .mask(mask), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one rising edge, let outputs settle before sampling.
  task automatic step(input logic r, input logic [N-1:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         valid;
    logic [1:0]   id;
    logic [N-1:0] mask;
    logic         timeout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic d,
                              input logic [N-1:0] g, input logic v, input logic [1:0] i,
                              input logic [N-1:0] m, input logic t);
    vec_t x;
    x.rst = r; x.req = q; x.done = d; x.gnt = g; x.valid = v; x.id = i; x.mask = m; x.timeout = t;
    return x;
  endfunction

  task automatic check_vec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    check({s, ".gnt"},       32'(gnt),       32'(v.gnt));
    check({s, ".gnt_valid"}, 32'(gnt_valid), 32'(v.valid));
    check({s, ".gnt_id"},    32'(gnt_id),    32'(v.id));
    check({s, ".mask"},      32'(mask),      32'(v.mask));
    check({s, ".timeout"},   32'(timeout),   32'(v.timeout));
    check({s, ".state"},     32'(fsm_state), v.valid ? 32'(BUSY) : 32'(IDLE));
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;

    //               rst req     done gnt     v  id mask    to
    // reset, req=1010, done, rotate to 3
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 0, 1, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 4'b1000, 1, 3, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 3, 4'b0000, 0));
    // req=1111 with done each grant: full rotation and wrap
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 1, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0100, 1, 2, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 2, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b1000, 1, 3, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 3, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 4'b1110, 0));
    // sole requester 0001 held: 4 grant cycles, timeout, idle, regrant
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 4'b1110, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b1110, 0));
    // get last_id=3, then 1001 falls back to unmasked pick of 0
    vecs.push_back(mk(0, 4'b1000, 0, 4'b1000, 1, 3, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b1000, 1, 4'b0000, 0, 3, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1001, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 4'b1110, 0));
    // gnt=0100 then withdrawal; no timeout
    vecs.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 2, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 2, 4'b1000, 0));
    // other req bits change during BUSY: no effect; done with limit same edge
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 4'b0010, 1, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 4'b0010, 1, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 4'b0010, 1, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 1, 4'b0000, 0, 1, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 4'b1000, 1, 3, 4'b1100, 0));
    // reset mid-grant, then 1111 grants index 0 first
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0, 4'b0000, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check_vec(i, vecs[i]);
    end

    // ---- hand sequence: count grant length of a sole requester ----
    begin
      int valid_cycles;
      int cyc;
      bit saw_release;
      step(1, 4'b0000, 0);
      check("hs1.reset_gnt", 32'(gnt), 32'd0);
      valid_cycles = 0;
      saw_release = 0;
      step(0, 4'b0001, 0);
      cyc = 0;
      while (cyc < 20 && !saw_release) begin
        if (gnt_valid) begin
          valid_cycles++;
          step(0, 4'b0001, 0);
        end else begin
          saw_release = 1;
        end
        cyc++;
      end
      check("hs1.released", 32'(saw_release), 32'd1);
      check("hs1.valid_cycles", 32'(valid_cycles), 32'(MH));
      check("hs1.timeout_pulse", 32'(timeout), 32'd1);
      step(0, 4'b0001, 0);
      check("hs1.regrant_gnt", 32'(gnt), 32'b0001);
      check("hs1.timeout_cleared", 32'(timeout), 32'd0);

      // ---- withdrawal on the limit edge: release without timeout ----
      for (int k = 0; k < MH - 1; k++) step(0, 4'b0001, 0);
      check("hs2.still_granted", 32'(gnt_valid), 32'd1);
      step(0, 4'b0000, 0);
      check("hs2.gnt_cleared", 32'(gnt), 32'd0);
      check("hs2.no_timeout", 32'(timeout), 32'd0);
      check("hs2.mask", 32'(mask), 32'b1110);
      // done while idle is ignored
      step(0, 4'b0000, 1);
      check("hs2.idle_done_mask", 32'(mask), 32'b1110);
      check("hs2.idle_done_valid", 32'(gnt_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
